// File: rtl/alu_exec_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, FSM states,
// multiply counts per convolution op and lane helpers.
package alu_exec_pkg;

  localparam int DATA_W = 32;
  localparam int LANE_W = 8;

  // ALUControl encodings produced by the ALU decoder
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_LOAD   = 3'b100;
  localparam logic [2:0] ALU_PWINO  = 3'b101;
  localparam logic [2:0] ALU_WINO   = 3'b110;
  localparam logic [2:0] ALU_CONV2D = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Number of multiplies each convolution op needs
  localparam logic [2:0] N_CONV2D = 3'd4;
  localparam logic [2:0] N_WINO   = 3'd4;
  localparam logic [2:0] N_PWINO  = 3'd3;

  // Sign-extend one packed 8-bit lane to the 10-bit multiplier operand width
  function automatic logic signed [9:0] lane_sx(input logic [LANE_W-1:0] lane);
    return {{(10-LANE_W){lane[LANE_W-1]}}, lane};
  endfunction

  // Counter value of the final multiply for a convolution op
  function automatic logic [2:0] last_cnt(input logic [2:0] op);
    case (op)
      ALU_PWINO: last_cnt = N_PWINO - 3'd1;
      ALU_WINO:  last_cnt = N_WINO - 3'd1;
      default:   last_cnt = N_CONV2D - 3'd1;
    endcase
  endfunction

  function automatic logic is_conv(input logic [2:0] op);
    return (op == ALU_PWINO) || (op == ALU_WINO) || (op == ALU_CONV2D);
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Combinational signed multiply-accumulate shared by all convolution ops.
// acc_out = (clear ? 0 : acc_in) +/- sign_extend(a*b)
module conv_mac_unit
  import alu_exec_pkg::*;
(
  input  logic signed [9:0]        a,
  input  logic signed [9:0]        b,
  input  logic        [DATA_W-1:0] acc_in,
  input  logic                     sub,
  input  logic                     clear,
  output logic        [DATA_W-1:0] acc_out
);

  logic signed [19:0]       prod;
  logic        [DATA_W-1:0] prod_ext;
  logic        [DATA_W-1:0] base;

  // Single signed multiplier, product sign-extended into the accumulator width
  always_comb begin
    prod     = a * b;
    prod_ext = {{(DATA_W-20){prod[19]}}, prod};
    base     = clear ? '0 : acc_in;
    acc_out  = sub ? (base - prod_ext) : (base + prod_ext);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub/and/or/load-address, and
// multi-cycle conv2d / Winograd F(2,3) / pruned Winograd on one shared MAC.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] Result,
  output logic             result_valid,
  output logic             Zero,
  output logic             Negative
);

  state_t            state_reg;
  logic [2:0]        op_reg;
  logic [2:0]        cnt_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [WIDTH-1:0]  acc_reg;   // conv2d accumulator, or y0 for Winograd ops
  logic [WIDTH-1:0]  y1_reg;
  logic [WIDTH-1:0]  result_reg;
  logic              result_valid_reg;
  logic              zero_reg;
  logic              negative_reg;

  logic [LANE-1:0]   a_lane [4];
  logic [LANE-1:0]   b_lane [4];
  logic signed [9:0] d [4];
  logic signed [9:0] g [4];

  logic signed [9:0] mac_a;
  logic signed [9:0] mac_b;
  logic [WIDTH-1:0]  mac_acc_in;
  logic              mac_sub;
  logic              mac_clear;
  logic [WIDTH-1:0]  mac_out;

  logic [WIDTH-1:0]  simple_res;
  logic [WIDTH-1:0]  conv_res;
  logic signed [WIDTH-1:0] y0_half;
  logic signed [WIDTH-1:0] y1_half;

  assign ready_out    = (state_reg == ST_IDLE);
  assign Result       = result_reg;
  assign result_valid = result_valid_reg;
  assign Zero         = zero_reg;
  assign Negative     = negative_reg;

  // Unpack the latched operands into sign-extended data and filter lanes
  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    assign a_lane[gi] = a_reg[gi*LANE +: LANE];
    assign b_lane[gi] = b_reg[gi*LANE +: LANE];
    assign d[gi]      = lane_sx(a_lane[gi]);
    assign g[gi]      = lane_sx(b_lane[gi]);
  end

  // Single-cycle op result, registered at the accept edge
  always_comb begin
    case (ALUControl)
      ALU_ADD, ALU_LOAD: simple_res = SrcA + SrcB;
      ALU_SUB:           simple_res = SrcA - SrcB;
      ALU_AND:           simple_res = SrcA & SrcB;
      ALU_OR:            simple_res = SrcA | SrcB;
      default:           simple_res = '0;
    endcase
  end

  // MAC operand selection per op and multiply step; Winograd terms carry an
  // extra factor of 2 so that no fractional filter transform is needed
  always_comb begin
    mac_a      = '0;
    mac_b      = '0;
    mac_acc_in = acc_reg;
    mac_sub    = 1'b0;
    mac_clear  = (cnt_reg == 3'd0);
    if (op_reg == ALU_CONV2D) begin
      mac_a = d[cnt_reg[1:0]];
      mac_b = g[cnt_reg[1:0]];
    end else begin
      case (cnt_reg)
        3'd0: begin
          mac_a = (d[0] - d[2]) <<< 1;
          mac_b = g[0];
        end
        3'd1: begin
          mac_a = d[1] + d[2];
          mac_b = g[0] + g[1] + g[2];
        end
        3'd2: begin
          mac_a = d[2] - d[1];
          mac_b = g[0] - g[1] + g[2];
        end
        default: begin
          mac_a      = (d[1] - d[3]) <<< 1;
          mac_b      = g[2];
          mac_acc_in = y1_reg;
          mac_sub    = 1'b1;
        end
      endcase
    end
  end

  conv_mac_unit u_mac (
    .a      (mac_a),
    .b      (mac_b),
    .acc_in (mac_acc_in),
    .sub    (mac_sub),
    .clear  (mac_clear),
    .acc_out(mac_out)
  );

  // Final result of a convolution op; the halving is exact since accs are even
  always_comb begin
    y0_half = $signed(acc_reg) >>> 1;
    y1_half = $signed(y1_reg) >>> 1;
    case (op_reg)
      ALU_CONV2D: conv_res = acc_reg;
      ALU_WINO:   conv_res = (y1_half << 16) | (y0_half & 32'h0000_FFFF);
      default:    conv_res = y0_half;
    endcase
  end

  // Control FSM, accumulators and registered result/flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      op_reg           <= ALU_ADD;
      cnt_reg          <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      acc_reg          <= '0;
      y1_reg           <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      zero_reg         <= 1'b1;
      negative_reg     <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (valid_in) begin
            if (is_conv(ALUControl)) begin
              op_reg    <= ALUControl;
              a_reg     <= SrcA;
              b_reg     <= SrcB;
              cnt_reg   <= '0;
              acc_reg   <= '0;
              y1_reg    <= '0;
              state_reg <= ST_MUL;
            end else begin
              result_reg       <= simple_res;
              result_valid_reg <= 1'b1;
              zero_reg         <= (simple_res == '0);
              negative_reg     <= simple_res[WIDTH-1];
            end
          end
        end
        ST_MUL: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (op_reg == ALU_CONV2D) begin
            acc_reg <= mac_out;
          end else begin
            // The MAC updates y0; y1 shares m2/m3, recovered as mac_out - y0
            case (cnt_reg)
              3'd0: begin
                acc_reg <= mac_out;
                y1_reg  <= '0;
              end
              3'd1: begin
                acc_reg <= mac_out;
                y1_reg  <= mac_out - acc_reg;
              end
              3'd2: begin
                acc_reg <= mac_out;
                y1_reg  <= y1_reg - (mac_out - acc_reg);
              end
              default: y1_reg <= mac_out;
            endcase
          end
          if (cnt_reg == last_cnt(op_reg)) state_reg <= ST_FIN;
        end
        ST_FIN: begin
          result_reg       <= conv_res;
          result_valid_reg <= 1'b1;
          zero_reg         <= (conv_res == '0);
          negative_reg     <= conv_res[WIDTH-1];
          state_reg        <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: expected results are queued when
// an op is issued and compared when result_valid pulses.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [2:0]  ALUControl = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] Result;
  logic        result_valid;
  logic        Zero;
  logic        Negative;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_rv  = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  int          rv_q  [$];

  alu_exec_unit #(.WIDTH(32), .LANE(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .ALUControl  (ALUControl),
    .SrcA        (SrcA),
    .SrcB        (SrcB),
    .Result      (Result),
    .result_valid(result_valid),
    .Zero        (Zero),
    .Negative    (Negative)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop and compare on every result pulse
  always @(posedge clk) begin
    logic [31:0] e;
    string       t;
    #1;
    if (result_valid === 1'b1) begin
      n_rv++;
      rv_q.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: Result=%h at cycle %0d, required no result", Result, cyc);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (Result !== e || Zero !== (e == 32'h0) || Negative !== e[31]) begin
          n_bad++;
          $display("FAIL %s: Result=%h Zero=%b Negative=%b, required Result=%h Zero=%b Negative=%b",
                   t, Result, Zero, Negative, e, (e == 32'h0), e[31]);
        end else begin
          $display("ok   %s: Result=%h Zero=%b Negative=%b cycle %0d", t, Result, Zero, Negative, cyc);
        end
      end
    end
  end

  // Issue one op (called at a negedge); waits for ready_out, returns the accept cycle
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input bit push, input string tag, output int ac);
    int waited = 0;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    valid_in   = 1'b1;
    if (push) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    while (ready_out !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (ready_out !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_accept_timeout: ready_out=%b, required 1", tag, ready_out);
    end
    @(posedge clk);
    #1;
    ac = cyc;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Wait (bounded) until every queued result has come back and the unit is idle
  task automatic wait_idle(output bit ok);
    int k = 0;
    while ((exp_q.size() != 0 || ready_out !== 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (Result !== 32'h0) begin n_bad++; $display("FAIL reset_result: Result=%h, required 00000000", Result); end
    if (Zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero: Zero=%b, required 1", Zero); end
    if (Negative !== 1'b0) begin n_bad++; $display("FAIL reset_negative: Negative=%b, required 0", Negative); end
    if (result_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: result_valid=%b, required 0", result_valid); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready: ready_out=%b, required 1", ready_out); end
  endtask

  task automatic test_simple();
    int ac;
    bit ok;
    rv_q.delete();
    send(3'b001, 32'd5, 32'd5, 32'h0, 1'b1, "sub_5_5", ac);
    n_cmp += 2;
    if (result_valid !== 1'b1) begin n_bad++; $display("FAIL sub_pulse_high: result_valid=%b, required 1", result_valid); end
    if (rv_q.size() != 1 || rv_q[0] - ac + 1 != 1) begin
      n_bad++; $display("FAIL sub_latency: %0d results, required 1 result at latency 1", rv_q.size());
    end
    @(negedge clk);
    n_cmp++;
    if (result_valid !== 1'b0) begin n_bad++; $display("FAIL sub_pulse_width: result_valid=%b, required 0", result_valid); end
    send(3'b000, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b1, "add_wrap", ac);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL add_wrap_drain: %0d results pending, required 0", exp_q.size()); end
  endtask

  task automatic test_conv2d();
    int ac;
    bit ok;
    rv_q.delete();
    send(3'b111, 32'h0403_0201, 32'h0101_0101, 32'h0000_000A, 1'b1, "conv2d_pos", ac);
    n_cmp++;
    if (ready_out !== 1'b0) begin n_bad++; $display("FAIL conv2d_busy: ready_out=%b, required 0", ready_out); end
    wait_idle(ok);
    n_cmp++;
    if (!ok || rv_q.size() != 1 || rv_q[0] - ac + 1 != 6) begin
      n_bad++; $display("FAIL conv2d_latency: %0d results, required 1 result at latency 6", rv_q.size());
    end
    rv_q.delete();
    send(3'b111, 32'h0403_0201, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b1, "conv2d_neg", ac);
    wait_idle(ok);
    n_cmp++;
    if (!ok || rv_q.size() != 1 || rv_q[0] - ac + 1 != 6) begin
      n_bad++; $display("FAIL conv2d_neg_latency: %0d results, required 1 result at latency 6", rv_q.size());
    end
  endtask

  task automatic test_winograd_held();
    int ac1, ac2;
    bit ok;
    rv_q.delete();
    send(3'b110, 32'h0403_0201, 32'h0001_0101, 32'h0009_0006, 1'b1, "winograd", ac1);
    // valid_in stays high with an add while the Winograd op is busy
    send(3'b000, 32'h10, 32'h20, 32'h30, 1'b1, "add_held", ac2);
    wait_idle(ok);
    n_cmp += 3;
    if (ac2 - ac1 != 6) begin
      n_bad++; $display("FAIL held_accept: accepted %0d cycles after winograd, required 6", ac2 - ac1);
    end
    if (!ok || rv_q.size() != 2) begin
      n_bad++; $display("FAIL held_count: %0d results, required 2", rv_q.size());
    end else begin
      if (rv_q[0] - ac1 + 1 != 6) begin
        n_bad++; $display("FAIL winograd_latency: latency %0d, required 6", rv_q[0] - ac1 + 1);
      end
      if (rv_q[1] - ac2 + 1 != 1) begin
        n_bad++; $display("FAIL held_add_latency: latency %0d, required 1", rv_q[1] - ac2 + 1);
      end
    end
  endtask

  task automatic test_pruned();
    int ac;
    bit ok;
    rv_q.delete();
    send(3'b101, 32'h0403_0201, 32'h0001_0101, 32'h0000_0006, 1'b1, "pruned_pos", ac);
    wait_idle(ok);
    n_cmp++;
    if (!ok || rv_q.size() != 1 || rv_q[0] - ac + 1 != 5) begin
      n_bad++; $display("FAIL pruned_latency: %0d results, required 1 result at latency 5", rv_q.size());
    end
    send(3'b101, 32'h0000_00FF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b1, "pruned_neg", ac);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL pruned_neg_drain: %0d results pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midop();
    int ac;
    int rv_before;
    bit ok;
    send(3'b111, 32'h0403_0201, 32'h0101_0101, 32'h0, 1'b0, "conv2d_abort", ac);
    rv_before = n_rv;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp += 2;
    if (Result !== 32'h0 || Zero !== 1'b1) begin
      n_bad++; $display("FAIL midop_reset_result: Result=%h Zero=%b, required 00000000 1", Result, Zero);
    end
    if (ready_out !== 1'b1) begin n_bad++; $display("FAIL midop_reset_ready: ready_out=%b, required 1", ready_out); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ready_out !== 1'b1) begin n_bad++; $display("FAIL midop_release_ready: ready_out=%b, required 1", ready_out); end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (n_rv != rv_before) begin
      n_bad++; $display("FAIL midop_no_pulse: %0d result pulses, required 0", n_rv - rv_before);
    end
    send(3'b000, 32'd7, 32'd8, 32'h0000_000F, 1'b1, "add_after_abort", ac);
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL add_after_abort_drain: %0d results pending, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int a1, a2, a3;
    bit ok;
    rv_q.delete();
    send(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, "b2b_and", a1);
    send(3'b011, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b1, "b2b_or", a2);
    send(3'b100, 32'h0000_0100, 32'h0000_0004, 32'h0000_0104, 1'b1, "b2b_load", a3);
    wait_idle(ok);
    n_cmp += 2;
    if (a2 - a1 != 1 || a3 - a2 != 1) begin
      n_bad++; $display("FAIL b2b_accept: gaps %0d,%0d, required 1,1", a2 - a1, a3 - a2);
    end
    if (!ok || rv_q.size() != 3 || rv_q[0] != a1 || rv_q[2] - rv_q[0] != 2) begin
      n_bad++; $display("FAIL b2b_valid_run: %0d results, required 3 on consecutive cycles", rv_q.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_simple();
    test_conv2d();
    test_winograd_held();
    test_pruned();
    test_reset_midop();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
